// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcodes, instruction field positions,
// the ID/EX bundle and the operand-usage helper used by Decode and Execute.
package pipeline_pkg;

  localparam int DATA_W = 16;
  localparam int IDX_W  = 5;
  localparam int IMM_W  = 7;
  localparam int OP_W   = 5;

  localparam int OP_LSB   = 27;
  localparam int DEST_LSB = 22;
  localparam int SRC1_LSB = 17;
  localparam int SRC2_LSB = 12;
  localparam int IMM_LSB  = 0;

  localparam logic [OP_W-1:0] OP_NOP   = 5'd0;
  localparam logic [OP_W-1:0] OP_LOAD  = 5'd1;
  localparam logic [OP_W-1:0] OP_STORE = 5'd2;
  localparam logic [OP_W-1:0] OP_ADD   = 5'd3;
  localparam logic [OP_W-1:0] OP_SUB   = 5'd4;
  localparam logic [OP_W-1:0] OP_AND   = 5'd5;
  localparam logic [OP_W-1:0] OP_OR    = 5'd6;
  localparam logic [OP_W-1:0] OP_ADDI  = 5'd7;
  localparam logic [OP_W-1:0] OP_BEQ   = 5'd8;
  localparam logic [OP_W-1:0] OP_JMP   = 5'd9;

  typedef struct packed {
    logic [OP_W-1:0]   control;
    logic [IDX_W-1:0]  dest;
    logic [DATA_W-1:0] reg1;
    logic [DATA_W-1:0] reg2;
    logic [DATA_W-1:0] npc;
    logic [IMM_W-1:0]  imm;
  } id_ex_t;

  // Immediate-form opcodes leave the src2 field unused.
  function automatic logic uses_src2(input logic [OP_W-1:0] op);
    logic r;
    case (op)
      OP_STORE, OP_ADD, OP_SUB,
      OP_AND, OP_OR, OP_BEQ: r = 1'b1;
      default:               r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// 32x16 register file: two async read ports with writeback bypass,
// one synchronous write port, cleared by synchronous reset.
module decode_regfile
  import pipeline_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int IW = IDX_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wb_en,
  input  logic [IW-1:0] wb_index,
  input  logic [DW-1:0] wb_data,
  input  logic [IW-1:0] rd1_index,
  input  logic [IW-1:0] rd2_index,
  output logic [DW-1:0] rd1_data,
  output logic [DW-1:0] rd2_data
);

  localparam int N = 2 ** IW;

  logic [DW-1:0] mem [N];
  logic          wr;

  assign wr = wb_en && (wb_index != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      mem <= '{default: '0};
    end else if (wr) begin
      mem[wb_index] <= wb_data;
    end
  end

  always_comb begin
    rd1_data = mem[rd1_index];
    rd2_data = mem[rd2_index];
    if (rd1_index == '0) begin
      rd1_data = '0;
    end else if (wr && wb_index == rd1_index) begin
      rd1_data = wb_data;
    end
    if (rd2_index == '0) begin
      rd2_data = '0;
    end else if (wr && wb_index == rd2_index) begin
      rd2_data = wb_data;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode: field split, operand read, load-use interlock,
// flush bubbles and the ID/EX pipeline register feeding Execute.
module decode_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W = pipeline_pkg::DATA_W,
  parameter int IDX_W  = pipeline_pkg::IDX_W,
  parameter int IMM_W  = pipeline_pkg::IMM_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  input  logic [DATA_W-1:0] npc_in,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [IDX_W-1:0]  wb_index,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall_out,
  output logic [4:0]        control_out,
  output logic [IDX_W-1:0]  dest_index_out,
  output logic [DATA_W-1:0] reg1_data,
  output logic [DATA_W-1:0] reg2_data,
  output logic [DATA_W-1:0] npc,
  output logic [IMM_W-1:0]  immediate
);

  logic [OP_W-1:0]   op;
  logic [IDX_W-1:0]  dest;
  logic [IDX_W-1:0]  src1;
  logic [IDX_W-1:0]  src2;
  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              hazard;
  id_ex_t            q;
  id_ex_t            d;

  assign op   = instr[OP_LSB   +: OP_W];
  assign dest = instr[DEST_LSB +: IDX_W];
  assign src1 = instr[SRC1_LSB +: IDX_W];
  assign src2 = instr[SRC2_LSB +: IDX_W];
  assign imm  = instr[IMM_LSB  +: IMM_W];

  decode_regfile #(
    .DW (DATA_W),
    .IW (IDX_W)
  ) u_rf (
    .clk       (clk),
    .reset     (reset),
    .wb_en     (wb_en),
    .wb_index  (wb_index),
    .wb_data   (wb_data),
    .rd1_index (src1),
    .rd2_index (src2),
    .rd1_data  (rd1),
    .rd2_data  (rd2)
  );

  // Load in Execute whose result a consumer here still needs.
  assign hazard = instr_valid
               && q.control == OP_LOAD
               && q.dest != '0
               && (q.dest == src1
                   || (uses_src2(op) && q.dest == src2));

  assign stall_out = hazard && !flush && !reset;

  always_comb begin
    d = '0;
    if (!(flush || hazard || !instr_valid)) begin
      d.control = op;
      d.dest    = dest;
      d.reg1    = rd1;
      d.reg2    = rd2;
      d.npc     = npc_in;
      d.imm     = imm;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

  assign control_out    = q.control;
  assign dest_index_out = q.dest;
  assign reg1_data      = q.reg1;
  assign reg2_data      = q.reg2;
  assign npc            = q.npc;
  assign immediate      = q.imm;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected ID/EX bundles are queued
// when a step is driven and compared one cycle later.
module tb_decode_stage;

  typedef struct packed {
    logic [4:0]  ctl;
    logic [4:0]  dest;
    logic [15:0] r1;
    logic [15:0] r2;
    logic [15:0] npc;
    logic [6:0]  imm;
  } exp_t;

  localparam exp_t BUB = '0;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic [15:0] npc_in;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_index;
  logic [15:0] wb_data;
  logic        stall_out;
  logic [4:0]  control_out;
  logic [4:0]  dest_index_out;
  logic [15:0] reg1_data;
  logic [15:0] reg2_data;
  logic [15:0] npc;
  logic [6:0]  immediate;

  int   checks = 0;
  int   errors = 0;
  exp_t sb [$];

  always #5 clk = ~clk;

  decode_stage dut (
    .clk            (clk),
    .reset          (reset),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .npc_in         (npc_in),
    .flush          (flush),
    .wb_en          (wb_en),
    .wb_index       (wb_index),
    .wb_data        (wb_data),
    .stall_out      (stall_out),
    .control_out    (control_out),
    .dest_index_out (dest_index_out),
    .reg1_data      (reg1_data),
    .reg2_data      (reg2_data),
    .npc            (npc),
    .immediate      (immediate)
  );

  function automatic logic [31:0] mk(
    input logic [4:0] op, input logic [4:0] de,
    input logic [4:0] s1, input logic [4:0] s2,
    input logic [6:0] im);
    return {op, de, s1, s2, 5'd0, im};
  endfunction

  function automatic exp_t ex(
    input logic [4:0] c, input logic [4:0] de,
    input logic [15:0] a, input logic [15:0] b,
    input logic [15:0] n, input logic [6:0] im);
    exp_t e;
    e.ctl = c; e.dest = de; e.r1 = a;
    e.r2 = b; e.npc = n; e.imm = im;
    return e;
  endfunction

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed %h required %h", tag, obs, req);
    end
  endtask

  task automatic step(
    input string       tag,
    input logic [31:0] ins,
    input logic        v,
    input logic [15:0] np,
    input logic        fl,
    input logic        rs,
    input logic        we,
    input logic [4:0]  wi,
    input logic [15:0] wd,
    input logic        exp_stall,
    input exp_t        e);
    exp_t got;
    instr = ins; instr_valid = v; npc_in = np;
    flush = fl; reset = rs;
    wb_en = we; wb_index = wi; wb_data = wd;
    #1;
    chk({tag, ".stall"}, 16'(stall_out), 16'(exp_stall));
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({tag, ".ctl"},  16'(control_out),    16'(got.ctl));
    chk({tag, ".dest"}, 16'(dest_index_out), 16'(got.dest));
    chk({tag, ".r1"},   reg1_data,           got.r1);
    chk({tag, ".r2"},   reg2_data,           got.r2);
    chk({tag, ".npc"},  npc,                 got.npc);
    chk({tag, ".imm"},  16'(immediate),      16'(got.imm));
  endtask

  localparam logic [4:0] LD  = 5'd1;
  localparam logic [4:0] ST  = 5'd2;
  localparam logic [4:0] ADD = 5'd3;
  localparam logic [4:0] ADI = 5'd7;

  initial begin
    reset = 1'b1; instr = '0; instr_valid = 1'b0;
    npc_in = '0; flush = 1'b0;
    wb_en = 1'b0; wb_index = '0; wb_data = '0;
    @(posedge clk); #1;

    step("rst0", mk(LD, 5'd6, 5'd1, 5'd2, 7'h11), 1, 16'h0010,
         0, 1, 0, 0, 0, 0, BUB);
    step("rst1", mk(ADD, 5'd6, 5'd6, 5'd6, 7'h11), 1, 16'h0011,
         0, 1, 0, 0, 0, 0, BUB);

    step("wb1", mk(ADD, 5'd9, 5'd1, 5'd1, 7'h1), 0, 16'h0001,
         0, 0, 1, 5'd1, 16'd10, 0, BUB);
    step("wb2", '0, 0, 0, 0, 0, 1, 5'd2, 16'd20, 0, BUB);
    step("wb5", '0, 0, 0, 0, 0, 1, 5'd5, 16'h5555, 0, BUB);
    step("wb6", '0, 0, 0, 0, 0, 1, 5'd6, 16'h0066, 0, BUB);

    step("norm", mk(ST, 5'd4, 5'd1, 5'd2, 7'h55), 1, 16'h0041,
         0, 0, 0, 0, 0, 0,
         ex(ST, 5'd4, 16'd10, 16'd20, 16'h0041, 7'h55));

    step("byp", mk(ADD, 5'd7, 5'd3, 5'd0, 7'h02), 1, 16'h0042,
         0, 0, 1, 5'd3, 16'hBEEF, 0,
         ex(ADD, 5'd7, 16'hBEEF, 16'h0, 16'h0042, 7'h02));
    step("r0wb", mk(ADD, 5'd7, 5'd0, 5'd3, 7'h03), 1, 16'h0043,
         0, 0, 1, 5'd0, 16'h1234, 0,
         ex(ADD, 5'd7, 16'h0, 16'hBEEF, 16'h0043, 7'h03));
    step("r0rd", mk(ADD, 5'd7, 5'd0, 5'd5, 7'h04), 1, 16'h0044,
         0, 0, 0, 0, 0, 0,
         ex(ADD, 5'd7, 16'h0, 16'h5555, 16'h0044, 7'h04));

    step("lu.ld", mk(LD, 5'd6, 5'd1, 5'd0, 7'h05), 1, 16'h0050,
         0, 0, 0, 0, 0, 0,
         ex(LD, 5'd6, 16'd10, 16'h0, 16'h0050, 7'h05));
    step("lu.stall", mk(ADD, 5'd8, 5'd1, 5'd6, 7'h06), 1, 16'h0051,
         0, 0, 0, 0, 0, 1, BUB);
    step("lu.issue", mk(ADD, 5'd8, 5'd1, 5'd6, 7'h06), 1, 16'h0051,
         0, 0, 0, 0, 0, 0,
         ex(ADD, 5'd8, 16'd10, 16'h0066, 16'h0051, 7'h06));

    step("z.ld", mk(LD, 5'd0, 5'd1, 5'd0, 7'h07), 1, 16'h0060,
         0, 0, 0, 0, 0, 0,
         ex(LD, 5'd0, 16'd10, 16'h0, 16'h0060, 7'h07));
    step("z.add", mk(ADD, 5'd8, 5'd0, 5'd0, 7'h08), 1, 16'h0061,
         0, 0, 0, 0, 0, 0,
         ex(ADD, 5'd8, 16'h0, 16'h0, 16'h0061, 7'h08));

    step("im.ld", mk(LD, 5'd6, 5'd2, 5'd0, 7'h09), 1, 16'h0070,
         0, 0, 0, 0, 0, 0,
         ex(LD, 5'd6, 16'd20, 16'h0, 16'h0070, 7'h09));
    step("im.s2", mk(ADI, 5'd8, 5'd2, 5'd6, 7'h0A), 1, 16'h0071,
         0, 0, 0, 0, 0, 0,
         ex(ADI, 5'd8, 16'd20, 16'h0066, 16'h0071, 7'h0A));
    step("im.ld2", mk(LD, 5'd6, 5'd2, 5'd0, 7'h0B), 1, 16'h0072,
         0, 0, 0, 0, 0, 0,
         ex(LD, 5'd6, 16'd20, 16'h0, 16'h0072, 7'h0B));
    step("im.s1", mk(ADI, 5'd8, 5'd6, 5'd0, 7'h0C), 1, 16'h0073,
         0, 0, 0, 0, 0, 1, BUB);

    step("fl.add", mk(ADD, 5'd9, 5'd1, 5'd2, 7'h0D), 1, 16'h0080,
         1, 0, 0, 0, 0, 0, BUB);
    step("fl.ld", mk(LD, 5'd6, 5'd1, 5'd0, 7'h0E), 1, 16'h0081,
         0, 0, 0, 0, 0, 0,
         ex(LD, 5'd6, 16'd10, 16'h0, 16'h0081, 7'h0E));
    step("fl.haz", mk(ADD, 5'd9, 5'd1, 5'd6, 7'h0F), 1, 16'h0082,
         1, 0, 0, 0, 0, 0, BUB);
    step("inv", mk(ADD, 5'd9, 5'd1, 5'd2, 7'h10), 0, 16'h0083,
         0, 0, 0, 0, 0, 0, BUB);

    step("rs.ld", mk(LD, 5'd6, 5'd1, 5'd0, 7'h11), 1, 16'h0090,
         0, 0, 0, 0, 0, 0,
         ex(LD, 5'd6, 16'd10, 16'h0, 16'h0090, 7'h11));
    step("rs.mid", mk(ADD, 5'd9, 5'd1, 5'd6, 7'h12), 1, 16'h0091,
         0, 1, 0, 0, 0, 0, BUB);
    step("rs.rd", mk(ADD, 5'd9, 5'd5, 5'd1, 7'h13), 1, 16'h0092,
         0, 0, 0, 0, 0, 0,
         ex(ADD, 5'd9, 16'h0, 16'h0, 16'h0092, 7'h13));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
